mapper_banked_offset: RTL

Parametrised banked cartridge mapper: the window starting at 0x4000 is split into `NUM_BANKS` banks of 2^`BANK_BITS` bytes, each with its own CPU-writable bank register. The block translates CPU memory accesses into physical RAM/ROM addresses. It sits beside the fixed-offset mapper in the per-slot mapper array and drives the same `mapper_out` / `device_bus` outputs. Bank-register writes are taken once per CPU write strobe via rising-edge detection, so a write held over many clocks counts as one write.

---
 rtl/mapper_banked_offset.sv | 119 +++++++++++
 1 files changed

// File: rtl/mapper_banked_offset.sv
// Banked cartridge mapper: the 0x4000 window is split into NUM_BANKS banks, each
// remapped by a CPU-writable bank register. Optional SRAM banking via MAPPER_BANKED_SRAM_EN.

module mapper_bank_reg #(
    parameter int                  REG_BITS = 8,
    parameter logic [REG_BITS-1:0] RST_VAL  = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [REG_BITS-1:0] data,
    output logic [REG_BITS-1:0] value
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     value <= RST_VAL;
        else if (load) value <= data;
    end
endmodule

module mapper_banked_offset #(
    parameter int          BANK_BITS      = 13,
    parameter int          NUM_BANKS      = 4,
    parameter int          REG_BITS       = 8,
    parameter logic [15:0] WR_BASE        = 16'h6000,
    parameter int          WR_STRIDE_LOG2 = 11,
    parameter int          TYP_W          = 3,
    parameter int          DEV_W          = 4,
    parameter logic [TYP_W-1:0] MAPPER_BANKED = 3'd2,
    parameter logic [DEV_W-1:0] DEV_NONE      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      cpu_addr,
    input  logic             cpu_mreq,
    input  logic             cpu_wr,
    input  logic [7:0]       cpu_data,
    input  logic [TYP_W-1:0] block_typ,
    input  logic [DEV_W-1:0] block_device,
    input  logic [26:0]      base_addr,
    input  logic [24:0]      rom_size,
    input  logic [26:0]      sram_base,
    input  logic [15:0]      sram_size,
    output logic             out_ram_cs,
    output logic [26:0]      out_addr,
    output logic             out_rnw,
    output logic [DEV_W-1:0] device_typ
);
    localparam int OFF_W  = REG_BITS + BANK_BITS;
    localparam int RIDX_W = 16 - WR_STRIDE_LOG2;
    localparam logic [16:0]       WIN_SIZE = 17'(NUM_BANKS * (1 << BANK_BITS));
    localparam logic [RIDX_W-1:0] REG_PAGE = RIDX_W'(WR_BASE >> WR_STRIDE_LOG2);

    logic [NUM_BANKS-1:0][REG_BITS-1:0] bank_reg;
    logic [NUM_BANKS-1:0]               load;
    logic [REG_BITS-1:0]                sel;
    logic [15:0]                        win_off, idx;
    logic [RIDX_W-1:0]                  reg_idx;
    logic [OFF_W-1:0]                   offset;
    logic [26:0]                        phys;
    logic cs, in_win, reg_hit, rom_ok, wr_q;

    assign cs      = (block_typ == MAPPER_BANKED) & cpu_mreq;
    assign win_off = cpu_addr - 16'h4000;
    assign in_win  = {1'b0, win_off} < WIN_SIZE;
    assign idx     = win_off >> BANK_BITS;
    assign reg_idx = cpu_addr[15:WR_STRIDE_LOG2] - REG_PAGE;
    assign reg_hit = cs & cpu_wr & (32'(reg_idx) < 32'(NUM_BANKS));

    // Held strobe counts once: only the first cycle of wr loads a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wr_q <= 1'b0;
        else       wr_q <= cpu_wr;
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        assign load[i] = reg_hit & ~wr_q & (reg_idx == RIDX_W'(i));
        mapper_bank_reg #(.REG_BITS(REG_BITS), .RST_VAL(REG_BITS'(i))) u_reg (
            .clk   (clk),
            .reset (reset),
            .load  (load[i]),
            .data  (cpu_data[REG_BITS-1:0]),
            .value (bank_reg[i])
        );
    end

    // Mux rather than direct index so out-of-window addresses never select past the array.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            if (idx == 16'(i)) sel = bank_reg[i];
    end

    assign offset     = {sel, cpu_addr[BANK_BITS-1:0]};
    assign phys       = base_addr + 27'(offset);
    assign rom_ok     = 32'(offset) < 32'(rom_size);
    assign device_typ = cs ? block_device : DEV_NONE;

`ifdef MAPPER_BANKED_SRAM_EN
    logic        is_sram;
    logic [26:0] sram_addr;
    logic        unused;

    assign is_sram    = sel[REG_BITS-1];
    assign sram_addr  = sram_base + 27'(cpu_addr[BANK_BITS-1:0] & BANK_BITS'(sram_size - 16'd1));
    assign out_ram_cs = cs & in_win & (is_sram | rom_ok);
    assign out_addr   = !out_ram_cs ? '1 : (is_sram ? sram_addr : phys);
    // Register writes are swallowed by the mapper even when they land in an SRAM bank.
    assign out_rnw    = ~(cs & in_win & is_sram & cpu_wr & ~reg_hit);
    assign unused     = ^cpu_data;
`else
    logic unused;

    assign out_ram_cs = cs & in_win & rom_ok;
    assign out_addr   = out_ram_cs ? phys : '1;
    assign out_rnw    = 1'b1;
    assign unused     = ^{sram_base, sram_size, cpu_data};
`endif

endmodule
